// File: rtl/rs_decoder_line_to_byte_fifo_if.sv
// Line-in / byte-out handshake bundle for the RS decoder FIFO.
// The FIFO takes the slave modport; the requestor/decoder side takes master.
interface rs_decoder_line_to_byte_fifo_if #(
  parameter int DEPTH = 512
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [511:0]  enq_data;
  logic          enq_en;
  logic          not_full;
  logic [7:0]    deq_data;
  logic          deq_en;
  logic          not_empty;
  logic [CW-1:0] counter;
  logic [CW-1:0] dec_counter;

  modport master (
    output enq_data, enq_en, deq_en,
    input  not_full, deq_data, not_empty, counter, dec_counter
  );

  modport slave (
    input  enq_data, enq_en, deq_en,
    output not_full, deq_data, not_empty, counter, dec_counter
  );
endinterface

// File: rtl/rs_decoder_line_to_byte_fifo.sv
// 64B-line in, 1B show-ahead out FIFO; deq_data is combinational, status flags follow the registered count one cycle later.
// Enqueues are dropped whole when fewer than 64 bytes are free; define REED_SOLOMON_DECODER_FIFO_OVERFLOW_CHECK_EN to flag and count drops.
module rs_decoder_line_to_byte_fifo #(
  parameter int REED_SOLOMON_DECODER_FIFO_DEPTH = 512
) (
  input  logic                          clk,
  input  logic                          reset,
  rs_decoder_line_to_byte_fifo_if.slave fifo_if
);
  localparam int DEPTH = REED_SOLOMON_DECODER_FIFO_DEPTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] dec_count_q, dec_count_d;
  logic [7:0]    mem_q [DEPTH];

  logic not_full, not_empty, enq_ok, deq_ok;

  assign not_full  = (count_q <= CW'(DEPTH - 64));
  assign not_empty = (count_q != '0);
  assign enq_ok    = fifo_if.enq_en && not_full;
  assign deq_ok    = fifo_if.deq_en && not_empty;

  assign fifo_if.not_full    = not_full;
  assign fifo_if.not_empty   = not_empty;
  assign fifo_if.deq_data    = not_empty ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_if.counter     = count_q;
  assign fifo_if.dec_counter = dec_count_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dec_count_d = dec_count_q;
    if (enq_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(64);
    end
    if (deq_ok) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      dec_count_d = dec_count_q + CW'(1);
    end
    case ({enq_ok, deq_ok})
      2'b10:   count_d = count_q + CW'(64);
      2'b01:   count_d = count_q - CW'(1);
      2'b11:   count_d = count_q + CW'(63);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dec_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dec_count_q <= dec_count_d;
    end
  end

  // wr_ptr is always line-aligned, so a line never straddles the wrap point.
  // Most significant byte lands at the lowest address so it leaves first.
  always_ff @(posedge clk) begin
    if (enq_ok) begin
      for (int j = 0; j < 64; j++) begin
        mem_q[wr_ptr_q + AW'(j)] <= fifo_if.enq_data[8*(63-j) +: 8];
      end
    end
  end

`ifdef REED_SOLOMON_DECODER_FIFO_OVERFLOW_CHECK_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (fifo_if.enq_en && !not_full) begin
      $error("fifo: enqueue dropped, full");
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end
`else
`endif
endmodule

// File: tb/tb_rs_decoder_line_to_byte_fifo.sv
// Bench for rs_decoder_line_to_byte_fifo: byte-queue reference model checked every cycle,
// plus hand-computed checkpoints for the directed scenarios.
module tb_rs_decoder_line_to_byte_fifo;
  localparam int DEPTH = 512;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   chk_en = 1'b0;

  int vectors = 0;
  int errors  = 0;

  rs_decoder_line_to_byte_fifo_if #(.DEPTH(DEPTH)) bus ();

  rs_decoder_line_to_byte_fifo #(.REED_SOLOMON_DECODER_FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (rst),
    .fifo_if (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: the FIFO is just an ordered queue of bytes.
  byte unsigned mq[$];
  int unsigned  mdec = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mdec = 0;
    end else begin
      bit ea, da;
      ea = bus.enq_en && (mq.size() + 64 <= DEPTH);
      da = bus.deq_en && (mq.size() > 0);
      if (da) begin
        void'(mq.pop_front());
        mdec++;
      end
      if (ea) begin
        for (int k = 63; k >= 0; k--) mq.push_back(bus.enq_data[8*k +: 8]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_counter",   32'(bus.counter),     32'(mq.size()));
      chk("m_dec",       32'(bus.dec_counter), mdec % (1 << CW));
      chk("m_not_full",  32'(bus.not_full),    32'(mq.size() + 64 <= DEPTH));
      chk("m_not_empty", 32'(bus.not_empty),   32'(mq.size() > 0));
      chk("m_deq_data",  32'(bus.deq_data),    (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic enq_line(input logic [511:0] d);
    bus.enq_data = d;
    bus.enq_en   = 1'b1;
    tick();
    bus.enq_en   = 1'b0;
  endtask

  task automatic pop_n(input int n);
    bus.deq_en = 1'b1;
    repeat (n) tick();
    bus.deq_en = 1'b0;
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    logic [511:0] line;
    bus.enq_data = '0;
    bus.enq_en   = 1'b0;
    bus.deq_en   = 1'b0;
    #2;
    rst    = 1'b1;
    #1;
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_counter",   32'(bus.counter),     32'd0);
    chk("rst_dec",       32'(bus.dec_counter), 32'd0);
    chk("rst_not_empty", 32'(bus.not_empty),   32'd0);
    chk("rst_not_full",  32'(bus.not_full),    32'd1);
    chk("rst_deq_data",  32'(bus.deq_data),    32'd0);

    // One line with byte k = k leaves as 63..0
    for (int k = 0; k < 64; k++) line[8*k +: 8] = 8'(k);
    enq_line(line);
    chk("one_line_counter", 32'(bus.counter), 32'd64);
    for (int i = 0; i < 64; i++) begin
      chk("one_line_byte", 32'(bus.deq_data), 32'(63 - i));
      pop_n(1);
    end
    chk("one_line_counter_end", 32'(bus.counter),     32'd0);
    chk("one_line_dec_end",     32'(bus.dec_counter), 32'd64);

    // Popping an empty FIFO is a no-op
    pop_n(5);
    chk("empty_pop_counter", 32'(bus.counter),     32'd0);
    chk("empty_pop_dec",     32'(bus.dec_counter), 32'd64);
    chk("empty_pop_data",    32'(bus.deq_data),    32'd0);

    // Fill to DEPTH, drop a 9th line, then free one line's worth
    do_reset();
    bus.enq_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.enq_data = {64{8'(8'h10 + i)}};
      tick();
    end
    bus.enq_en = 1'b0;
    chk("full_counter",  32'(bus.counter),  32'd512);
    chk("full_not_full", 32'(bus.not_full), 32'd0);
    enq_line({64{8'hEE}});
    chk("drop_counter", 32'(bus.counter), 32'd512);
`ifdef REED_SOLOMON_DECODER_FIFO_OVERFLOW_CHECK_EN
    chk("drop_count", 32'(dut.drop_cnt_q), 32'd1);
`endif
    chk("full_head", 32'(bus.deq_data), 32'h10);
    pop_n(64);
    chk("freed_not_full", 32'(bus.not_full), 32'd1);
    chk("freed_counter",  32'(bus.counter),  32'd448);

    // Simultaneous enq+deq at DEPTH-64
    chk("both_head", 32'(bus.deq_data), 32'h11);
    bus.enq_data = {64{8'hAB}};
    bus.enq_en   = 1'b1;
    bus.deq_en   = 1'b1;
    tick();
    bus.enq_en   = 1'b0;
    bus.deq_en   = 1'b0;
    chk("both_counter",  32'(bus.counter),  32'd511);
    chk("both_not_full", 32'(bus.not_full), 32'd0);
    chk("both_next",     32'(bus.deq_data), 32'h11);

    // 20 lines through the buffer, crossing the pointer wrap
    do_reset();
    for (int i = 0; i < 6; i++) enq_line(rand_line());
    for (int i = 0; i < 14; i++) begin
      pop_n(64);
      enq_line(rand_line());
    end
    pop_n(384);
    chk("wrap_counter", 32'(bus.counter),     32'd0);
    chk("wrap_dec",     32'(bus.dec_counter), 32'd256);

    // Random traffic with an asynchronous reset in the middle
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.enq_data = rand_line();
      bus.enq_en   = ($urandom_range(0, 3) == 0);
      bus.deq_en   = ($urandom_range(0, 9) < 7);
      if (c == 1500) begin
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_counter", 32'(bus.counter),  32'd0);
        chk("async_rst_data",    32'(bus.deq_data), 32'd0);
        tick();
        rst = 1'b0;
      end
      tick();
    end
    bus.enq_en = 1'b0;
    bus.deq_en = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
